// File: rtl/ascon128_encrypt_top.sv
// Ascon-128 (v1.2) AEAD core: one 64-bit AD block, one 64-bit PT block, one round per cycle.
// Define ASCON_DONE_EN to add a one-cycle DONE pulse registered alongside C/T.
module ascon128_encrypt_top #(
  parameter logic [63:0] IV = 64'h80400C0600000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [63:0]  P,
  output logic [63:0]  C,
  output logic [127:0] T
`ifdef ASCON_DONE_EN
  ,
  output logic         DONE
`endif
);

  localparam logic [63:0] PAD = 64'h8000000000000000;

  typedef enum logic [2:0] {
    PH_LOAD,
    PH_INIT,
    PH_AD1,
    PH_AD2,
    PH_PT,
    PH_FIN,
    PH_OUT
  } phase_t;

  phase_t       phase;
  phase_t       phase_after;
  logic [3:0]   rnd;
  logic [63:0]  x0, x1, x2, x3, x4;
  logic [127:0] sk_q;
  logic [63:0]  a_q, p_q;
  logic [63:0]  c_int, c_next;
  logic [127:0] t_int, t_next;

  logic         long_perm;
  logic         last_round;
  logic [3:0]   rc_idx;
  logic [7:0]   rc;

  logic [63:0]  b0, b1, b2, b3, b4;
  logic [63:0]  t0, t1, t2, t3, t4;
  logic [63:0]  m0, m1, m2, m3, m4;
  logic [63:0]  s0, s1, s2, s3, s4;
  logic [63:0]  l0, l1, l2, l3, l4;
  logic [63:0]  n0, n1, n2, n3, n4;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned amt);
    return (v >> amt) | (v << (64 - amt));
  endfunction

  // p6 runs the last six constants of the p12 schedule; constant i is {~i, i}.
  assign long_perm  = (phase == PH_INIT) || (phase == PH_FIN);
  assign last_round = long_perm ? (rnd == 4'd11) : (rnd == 4'd5);
  assign rc_idx     = long_perm ? rnd : rnd + 4'd6;
  assign rc         = {~rc_idx, rc_idx};

  always_comb begin
    b0 = x0 ^ x4;
    b1 = x1;
    b2 = x2 ^ {56'h0, rc} ^ x1;
    b3 = x3;
    b4 = x4 ^ x3;

    t0 = ~b0 & b1;
    t1 = ~b1 & b2;
    t2 = ~b2 & b3;
    t3 = ~b3 & b4;
    t4 = ~b4 & b0;

    m0 = b0 ^ t1;
    m1 = b1 ^ t2;
    m2 = b2 ^ t3;
    m3 = b3 ^ t4;
    m4 = b4 ^ t0;

    s0 = m0 ^ m4;
    s1 = m1 ^ m0;
    s2 = ~m2;
    s3 = m3 ^ m2;
    s4 = m4;

    l0 = s0 ^ rotr(s0, 19) ^ rotr(s0, 28);
    l1 = s1 ^ rotr(s1, 61) ^ rotr(s1, 39);
    l2 = s2 ^ rotr(s2, 1)  ^ rotr(s2, 6);
    l3 = s3 ^ rotr(s3, 10) ^ rotr(s3, 17);
    l4 = s4 ^ rotr(s4, 7)  ^ rotr(s4, 41);
  end

  // Phase-boundary XORs land on the output of each phase's final round.
  always_comb begin
    n0          = l0;
    n1          = l1;
    n2          = l2;
    n3          = l3;
    n4          = l4;
    c_next      = c_int;
    t_next      = t_int;
    phase_after = phase;
    case (phase)
      PH_INIT: begin
        phase_after = PH_AD1;
        if (last_round) begin
          n0 = l0 ^ a_q;
          n3 = l3 ^ sk_q[127:64];
          n4 = l4 ^ sk_q[63:0];
        end
      end
      PH_AD1: begin
        phase_after = PH_AD2;
        if (last_round) n0 = l0 ^ PAD;
      end
      PH_AD2: begin
        phase_after = PH_PT;
        if (last_round) begin
          n4     = l4 ^ 64'h1;
          c_next = l0 ^ p_q;
          n0     = l0 ^ p_q;
        end
      end
      PH_PT: begin
        phase_after = PH_FIN;
        if (last_round) begin
          n0 = l0 ^ PAD;
          n1 = l1 ^ sk_q[127:64];
          n2 = l2 ^ sk_q[63:0];
        end
      end
      PH_FIN: begin
        phase_after = PH_OUT;
        if (last_round) t_next = {l3, l4} ^ sk_q;
      end
      default: phase_after = phase;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= PH_LOAD;
      rnd   <= 4'd0;
      x0    <= 64'h0;
      x1    <= 64'h0;
      x2    <= 64'h0;
      x3    <= 64'h0;
      x4    <= 64'h0;
      sk_q  <= 128'h0;
      a_q   <= 64'h0;
      p_q   <= 64'h0;
      c_int <= 64'h0;
      t_int <= 128'h0;
      C     <= 64'h0;
      T     <= 128'h0;
`ifdef ASCON_DONE_EN
      DONE  <= 1'b0;
`endif
    end else begin
`ifdef ASCON_DONE_EN
      DONE <= 1'b0;
`endif
      case (phase)
        PH_LOAD: begin
          sk_q  <= SK;
          a_q   <= A;
          p_q   <= P;
          x0    <= IV;
          x1    <= SK[127:64];
          x2    <= SK[63:0];
          x3    <= N[127:64];
          x4    <= N[63:0];
          rnd   <= 4'd0;
          phase <= PH_INIT;
        end
        PH_OUT: begin
          C     <= c_int;
          T     <= t_int;
`ifdef ASCON_DONE_EN
          DONE  <= 1'b1;
`endif
          phase <= PH_LOAD;
        end
        default: begin
          x0    <= n0;
          x1    <= n1;
          x2    <= n2;
          x3    <= n3;
          x4    <= n4;
          c_int <= c_next;
          t_int <= t_next;
          if (last_round) begin
            rnd   <= 4'd0;
            phase <= phase_after;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon128_encrypt_top.sv
// Bench for ascon128_encrypt_top: random and known-answer vectors against a table-driven Ascon model.
// Builds with or without ASCON_DONE_EN.
module tb_ascon128_encrypt_top;

  localparam logic [63:0] IV  = 64'h80400C0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] sk, nonce;
  logic [63:0]  ad, pt;
  logic [63:0]  c;
  logic [127:0] t;
`ifdef ASCON_DONE_EN
  logic         done;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int since_rel = 0;

  always #5 clk = ~clk;

  ascon128_encrypt_top dut (
    .CLK(clk),
    .RST(rst),
    .SK(sk),
    .N(nonce),
    .A(ad),
    .P(pt),
    .C(c),
    .T(t)
`ifdef ASCON_DONE_EN
    ,
    .DONE(done)
`endif
  );

  function automatic logic [63:0] rotr(input logic [63:0] v, input int amt);
    return (v >> amt) | (v << (64 - amt));
  endfunction

  function automatic logic [4:0] sbox5(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  // Column-wise S-box lookup over the five words, last nr constants of the p12 schedule.
  function automatic logic [319:0] perm(input logic [319:0] st, input int nr);
    logic [63:0] w[5];
    logic [4:0]  col;
    logic [7:0]  rcon;
    int          ra[5];
    int          rb[5];
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) w[i] = st[319-64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      rcon = 8'hF0 - 8'(r * 15);
      w[2] = w[2] ^ {56'h0, rcon};
      for (int b = 0; b < 64; b++) begin
        col = sbox5({w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]});
        w[0][b] = col[4];
        w[1][b] = col[3];
        w[2][b] = col[2];
        w[3][b] = col[1];
        w[4][b] = col[0];
      end
      for (int i = 0; i < 5; i++) w[i] = w[i] ^ rotr(w[i], ra[i]) ^ rotr(w[i], rb[i]);
    end
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  function automatic logic [191:0] model(input logic [127:0] k, input logic [127:0] n,
                                         input logic [63:0] a, input logic [63:0] p);
    logic [319:0] s;
    logic [63:0]  ct;
    logic [127:0] tg;
    s = perm({IV, k, n}, 12);
    s[127:0]   = s[127:0] ^ k;
    s[319:256] = s[319:256] ^ a;
    s = perm(s, 6);
    s[319:256] = s[319:256] ^ PAD;
    s = perm(s, 6);
    s[0] = s[0] ^ 1'b1;
    ct = s[319:256] ^ p;
    s[319:256] = ct;
    s = perm(s, 6);
    s[319:256] = s[319:256] ^ PAD;
    s[255:128] = s[255:128] ^ k;
    s = perm(s, 12);
    tg = s[127:0] ^ k;
    return {ct, tg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    since_rel++;
  endtask

  task automatic tick_to(input int e);
    while (since_rel < e) tick();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    since_rel = 0;
  endtask

  task automatic rand_inputs();
    sk    = {$urandom, $urandom, $urandom, $urandom};
    nonce = {$urandom, $urandom, $urandom, $urandom};
    ad    = {$urandom, $urandom};
    pt    = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rand_inputs();
    tick();
    tick();
    n_checks++;
    if ({c, t} !== 192'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {c, t});
    end
`ifdef ASCON_DONE_EN
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
`endif
    release_reset();
  endtask

  // LOAD is the first edge after release, so the result shows on edge 44.
  task automatic test_kat();
    logic [191:0] exp;
    sk    = 128'h000102030405060708090A0B0C0D0E0F;
    nonce = 128'h000102030405060708090A0B0C0D0E0F;
    ad    = 64'h0001020304050607;
    pt    = 64'h0001020304050607;
    exp   = model(sk, nonce, ad, pt);
    tick_to(43);
    n_checks++;
    if ({c, t} !== 192'h0) begin
      n_fail++;
      $display("[TB] FAIL kat_early: got %h expected 0", {c, t});
    end
`ifdef ASCON_DONE_EN
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL kat_done_early: got %b expected 0", done);
    end
`endif
    tick_to(44);
    n_checks++;
    if ({c, t} !== exp) begin
      n_fail++;
      $display("[TB] FAIL kat_result: got %h expected %h", {c, t}, exp);
    end
`ifdef ASCON_DONE_EN
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL kat_done: got %b expected 1", done);
    end
`endif
  endtask

  task automatic test_zero();
    logic [191:0] exp;
    sk = '0; nonce = '0; ad = '0; pt = '0;
    exp = model(sk, nonce, ad, pt);
    tick_to(88);
    n_checks++;
    if ({c, t} !== exp) begin
      n_fail++;
      $display("[TB] FAIL zero_first: got %h expected %h", {c, t}, exp);
    end
    tick_to(100);
    n_checks++;
    if ({c, t} !== exp) begin
      n_fail++;
      $display("[TB] FAIL zero_hold: got %h expected %h", {c, t}, exp);
    end
`ifdef ASCON_DONE_EN
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_done_low: got %b expected 0", done);
    end
`endif
    tick_to(132);
    n_checks++;
    if ({c, t} !== exp) begin
      n_fail++;
      $display("[TB] FAIL zero_second: got %h expected %h", {c, t}, exp);
    end
  endtask

  task automatic test_stability();
    logic [191:0] prev, exp1, exp2;
    prev = model('0, '0, '0, '0);
    rand_inputs();
    exp1 = model(sk, nonce, ad, pt);
    tick_to(137);
    rand_inputs();
    exp2 = model(sk, nonce, ad, pt);
    tick_to(175);
    n_checks++;
    if ({c, t} !== prev) begin
      n_fail++;
      $display("[TB] FAIL stab_hold: got %h expected %h", {c, t}, prev);
    end
    tick_to(176);
    n_checks++;
    if ({c, t} !== exp1) begin
      n_fail++;
      $display("[TB] FAIL stab_sampled: got %h expected %h", {c, t}, exp1);
    end
    tick_to(220);
    n_checks++;
    if ({c, t} !== exp2) begin
      n_fail++;
      $display("[TB] FAIL stab_next: got %h expected %h", {c, t}, exp2);
    end
  endtask

  task automatic test_back_to_back(input logic [191:0] prev_in);
    logic [191:0] prev, exp;
    int           ld;
    prev = prev_in;
    for (int i = 0; i < 3; i++) begin
      ld = 221 + 44 * i;
      rand_inputs();
      exp = model(sk, nonce, ad, pt);
      tick_to(ld + 20);
      n_checks++;
      if ({c, t} !== prev) begin
        n_fail++;
        $display("[TB] FAIL b2b_mid%0d: got %h expected %h", i, {c, t}, prev);
      end
      tick_to(ld + 42);
      n_checks++;
      if ({c, t} !== prev) begin
        n_fail++;
        $display("[TB] FAIL b2b_pre%0d: got %h expected %h", i, {c, t}, prev);
      end
      tick_to(ld + 43);
      n_checks++;
      if ({c, t} !== exp) begin
        n_fail++;
        $display("[TB] FAIL b2b_out%0d: got %h expected %h", i, {c, t}, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_reset_fin();
    logic [191:0] exp;
    int           ld;
    ld = 353;
    rand_inputs();
    tick_to(ld + 35);
    #4;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({c, t} !== 192'h0) begin
      n_fail++;
      $display("[TB] FAIL rstfin_clear: got %h expected 0", {c, t});
    end
    release_reset();
    rand_inputs();
    exp = model(sk, nonce, ad, pt);
    tick_to(43);
    n_checks++;
    if ({c, t} !== 192'h0) begin
      n_fail++;
      $display("[TB] FAIL rstfin_early: got %h expected 0", {c, t});
    end
    tick_to(44);
    n_checks++;
    if ({c, t} !== exp) begin
      n_fail++;
      $display("[TB] FAIL rstfin_fresh: got %h expected %h", {c, t}, exp);
    end
  endtask

  logic [191:0] last_stab;

  initial begin
    rst = 1'b1;
    sk = '0; nonce = '0; ad = '0; pt = '0;
    test_reset();
    test_kat();
    test_zero();
    test_stability();
    last_stab = model(sk, nonce, ad, pt);
    test_back_to_back(last_stab);
    test_reset_fin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
